// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back entry payload used by the
// write-port arbiter and its port-B FIFO.
package regfile_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic              live;
    } wb_entry_t;

endpackage

// File: rtl/wb_kill_fifo.sv
// Circular buffer of pending port-B writes. Entries can be killed by destination
// so an older queued write never overwrites a newer pipeline result.
module wb_kill_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [ADDR_W-1:0]          push_dest_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    input  logic                       kill_en_i,
    input  logic [ADDR_W-1:0]          kill_dest_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [NUM_REGS-1:0]        busy_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t            mem_q [DEPTH];
    wb_entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;

    // Kill sees only pre-existing entries; the push below overrides it so a
    // same-cycle push stays live. Popped slots are cleared so dead slots never
    // contribute to the busy mask.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        busy_d   = '0;

        if (kill_en_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (mem_q[i].dest == kill_dest_i) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end
        if (pop_i) begin
            mem_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d             = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{dest: push_dest_i, data: push_data_i, live: 1'b1};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem_d[i].live) begin
                busy_d[mem_d[i].dest] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign busy_mask_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the never-stalled
// pipeline write-back (port A) and a FIFO-buffered secondary producer (port B).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_en_i,
    input  logic [ADDR_W-1:0]   a_dest_i,
    input  logic [DATA_W-1:0]   a_data_i,
    input  logic                b_valid_i,
    input  logic [ADDR_W-1:0]   b_dest_i,
    input  logic [DATA_W-1:0]   b_data_i,
    output logic                b_ready_o,
    output logic                wb_en_o,
    output logic [ADDR_W-1:0]   wb_dest_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [NUM_REGS-1:0] busy_mask_o,
    output logic                stall_req_o,
    output logic                idle_o
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t          head;
    logic [CNT_W-1:0]   count;
    logic               non_empty;
    logic               push;
    logic               pop;

    logic               wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]  wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    wb_kill_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_dest_i (b_dest_i),
        .push_data_i (b_data_i),
        .pop_i       (pop),
        .kill_en_i   (a_en_i),
        .kill_dest_i (a_dest_i),
        .head_o      (head),
        .count_o     (count),
        .busy_mask_o (busy_mask_o)
    );

    assign non_empty = (count != '0);
    assign push      = b_valid_i && b_ready_o;

    // A always owns the port; a dead head is discarded even while A writes.
    always_comb begin
        pop       = 1'b0;
        wb_en_d   = 1'b0;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        wait_d    = wait_q;

        if (a_en_i) begin
            wb_en_d   = 1'b1;
            wb_dest_d = a_dest_i;
            wb_data_d = a_data_i;
        end

        if (!non_empty) begin
            wait_d = '0;
        end else if (!head.live || !a_en_i) begin
            pop    = 1'b1;
            wait_d = '0;
            if (head.live) begin
                wb_en_d   = 1'b1;
                wb_dest_d = head.dest;
                wb_data_d = head.data;
            end
        end else if (wait_q < WAIT_W'(STARVE_LIMIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
            wait_q    <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
            wait_q    <= wait_d;
        end
    end

    assign b_ready_o   = !rst && (count < CNT_W'(DEPTH));
    assign wb_en_o     = wb_en_q;
    assign wb_dest_o   = wb_dest_q;
    assign wb_data_o   = wb_data_q;
    assign stall_req_o = non_empty && head.live && (wait_q >= WAIT_W'(STARVE_LIMIT));
    assign idle_o      = !non_empty;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, port A, port B flow, full FIFO,
// kill ordering, starvation and reset with queued entries.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0;
    logic [3:0]  a_dest = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic [3:0]  b_dest = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [15:0] busy_mask;
    logic        stall_req;
    logic        idle;

    int checks = 0;
    int passes = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_en_i      (a_en),
        .a_dest_i    (a_dest),
        .a_data_i    (a_data),
        .b_valid_i   (b_valid),
        .b_dest_i    (b_dest),
        .b_data_i    (b_data),
        .b_ready_o   (b_ready),
        .wb_en_o     (wb_en),
        .wb_dest_o   (wb_dest),
        .wb_data_o   (wb_data),
        .busy_mask_o (busy_mask),
        .stall_req_o (stall_req),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        a_en    = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_valid = 1'b1; b_dest = 4'd2; b_data = 32'h77;
        step();
        checks++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready got %b exp 0", b_ready); else passes++;
        step();
        checks++; if (wb_en !== 1'b0 || wb_dest !== 4'd0 || wb_data !== 32'd0)
            $display("FAIL rst_wb got en=%b dest=%h data=%h exp 0/0/0", wb_en, wb_dest, wb_data); else passes++;
        checks++; if (busy_mask !== 16'h0 || idle !== 1'b1 || stall_req !== 1'b0)
            $display("FAIL rst_state got busy=%h idle=%b stall=%b exp 0/1/0", busy_mask, idle, stall_req); else passes++;
        rst = 1'b0; quiet();
        #1;
        checks++; if (b_ready !== 1'b1) $display("FAIL rel_b_ready got %b exp 1", b_ready); else passes++;
        step();
        checks++; if (idle !== 1'b1 || wb_en !== 1'b0)
            $display("FAIL rel_empty got idle=%b wb_en=%b exp 1/0", idle, wb_en); else passes++;
    endtask

    task automatic test_a_only();
        a_en = 1'b1; a_dest = 4'd3; a_data = 32'hDEADBEEF;
        step();
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd3 || wb_data !== 32'hDEADBEEF)
            $display("FAIL a_write got en=%b dest=%h data=%h exp 1/3/deadbeef", wb_en, wb_dest, wb_data); else passes++;
        quiet();
        step();
        checks++; if (wb_en !== 1'b0 || wb_dest !== 4'd3)
            $display("FAIL a_idle got en=%b dest=%h exp 0/3", wb_en, wb_dest); else passes++;
    endtask

    task automatic test_b_flow();
        b_valid = 1'b1; b_dest = 4'd5; b_data = 32'h11;
        step();
        quiet();
        checks++; if (busy_mask !== 16'h0020 || wb_en !== 1'b0 || idle !== 1'b0)
            $display("FAIL b_push got busy=%h en=%b idle=%b exp 0020/0/0", busy_mask, wb_en, idle); else passes++;
        step();
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_data !== 32'h11)
            $display("FAIL b_drain got en=%b dest=%h data=%h exp 1/5/11", wb_en, wb_dest, wb_data); else passes++;
        checks++; if (busy_mask !== 16'h0 || idle !== 1'b1)
            $display("FAIL b_clear got busy=%h idle=%b exp 0/1", busy_mask, idle); else passes++;
        step();
        checks++; if (wb_en !== 1'b0) $display("FAIL b_once got en=%b exp 0", wb_en); else passes++;
    endtask

    task automatic test_full();
        a_en = 1'b1; a_dest = 4'd0;
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hA0 + 32'(i);
            b_valid = 1'b1; b_dest = 4'(i + 1); b_data = 32'h100 + 32'(i);
            step();
        end
        checks++; if (b_ready !== 1'b0 || busy_mask !== 16'h001E)
            $display("FAIL full_state got ready=%b busy=%h exp 0/001e", b_ready, busy_mask); else passes++;
        checks++; if (wb_en !== 1'b1 || wb_data !== 32'hA3)
            $display("FAIL full_a_wins got en=%b data=%h exp 1/a3", wb_en, wb_data); else passes++;
        b_dest = 4'd9; b_data = 32'h999;
        step();
        b_valid = 1'b0; a_en = 1'b0;
        checks++; if (busy_mask !== 16'h001E || b_ready !== 1'b0)
            $display("FAIL full_reject got busy=%h ready=%b exp 001e/0", busy_mask, b_ready); else passes++;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (wb_en !== 1'b1 || wb_dest !== 4'(i + 1) || wb_data !== 32'h100 + 32'(i))
                $display("FAIL full_drain%0d got en=%b dest=%h data=%h exp 1/%h/%h",
                         i, wb_en, wb_dest, wb_data, i + 1, 32'h100 + 32'(i)); else passes++;
        end
        step();
        checks++; if (wb_en !== 1'b0 || idle !== 1'b1)
            $display("FAIL full_end got en=%b idle=%b exp 0/1", wb_en, idle); else passes++;
    endtask

    task automatic test_kill();
        b_valid = 1'b1; b_dest = 4'd7; b_data = 32'h22;
        step();
        b_valid = 1'b0; a_en = 1'b1; a_dest = 4'd7; a_data = 32'h33;
        step();
        quiet();
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd7 || wb_data !== 32'h33)
            $display("FAIL kill_a got en=%b dest=%h data=%h exp 1/7/33", wb_en, wb_dest, wb_data); else passes++;
        checks++; if (busy_mask !== 16'h0 || idle !== 1'b0)
            $display("FAIL kill_mask got busy=%h idle=%b exp 0/0", busy_mask, idle); else passes++;
        step();
        checks++; if (wb_en !== 1'b0 || idle !== 1'b1 || wb_data !== 32'h33)
            $display("FAIL kill_pop got en=%b idle=%b data=%h exp 0/1/33", wb_en, idle, wb_data); else passes++;
        step();
        checks++; if (wb_en !== 1'b0) $display("FAIL kill_nowrite got en=%b exp 0", wb_en); else passes++;
    endtask

    task automatic test_same_cycle();
        b_valid = 1'b1; b_dest = 4'd9; b_data = 32'hAA;
        a_en = 1'b1; a_dest = 4'd9; a_data = 32'hBB;
        step();
        quiet();
        checks++; if (wb_data !== 32'hBB || busy_mask !== 16'h0200)
            $display("FAIL same_a got data=%h busy=%h exp bb/0200", wb_data, busy_mask); else passes++;
        step();
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd9 || wb_data !== 32'hAA)
            $display("FAIL same_b got en=%b dest=%h data=%h exp 1/9/aa", wb_en, wb_dest, wb_data); else passes++;
    endtask

    task automatic test_starve();
        b_valid = 1'b1; b_dest = 4'd4; b_data = 32'h44;
        a_en = 1'b1; a_dest = 4'd1; a_data = 32'h55;
        step();
        b_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++; if (stall_req !== (k >= 8))
                $display("FAIL starve_k%0d got %b exp %b", k, stall_req, k >= 8); else passes++;
        end
        checks++; if (wb_en !== 1'b1 || wb_data !== 32'h55)
            $display("FAIL starve_a got en=%b data=%h exp 1/55", wb_en, wb_data); else passes++;
        a_en = 1'b0;
        step();
        checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd4 || wb_data !== 32'h44 || stall_req !== 1'b0)
            $display("FAIL starve_drain got en=%b dest=%h data=%h stall=%b exp 1/4/44/0",
                     wb_en, wb_dest, wb_data, stall_req); else passes++;
    endtask

    task automatic test_mid_reset();
        b_valid = 1'b1; b_dest = 4'd6; b_data = 32'h66;
        a_en = 1'b1; a_dest = 4'd1; a_data = 32'h01;
        step();
        b_dest = 4'd8; b_data = 32'h88;
        step();
        checks++; if (busy_mask !== 16'h0140)
            $display("FAIL mid_queued got busy=%h exp 0140", busy_mask); else passes++;
        quiet(); rst = 1'b1;
        step();
        checks++; if (idle !== 1'b1 || busy_mask !== 16'h0 || wb_en !== 1'b0)
            $display("FAIL mid_rst got idle=%b busy=%h en=%b exp 1/0/0", idle, busy_mask, wb_en); else passes++;
        rst = 1'b0;
        step();
        step();
        checks++; if (wb_en !== 1'b0 || idle !== 1'b1)
            $display("FAIL mid_discard got en=%b idle=%b exp 0/1", wb_en, idle); else passes++;
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_flow();
        test_full();
        test_kill();
        test_same_cycle();
        test_starve();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
